// File: rtl/nco_param.sv
// nco_param: phase accumulator with programmable FCW/offset, quadrant fold and
// NSTG-stage pipelined CORDIC producing quadrature samples NSTG+2 edges after En.
module nco_param #(
    parameter int unsigned PW          = 24,
    parameter int unsigned AW          = 16,
    parameter int unsigned OW          = 12,
    parameter int unsigned NSTG        = 12,
    parameter int unsigned UPD_ON_WRAP = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          En,
    input  logic          Ld,
    input  logic [PW-1:0] FCW,
    input  logic [PW-1:0] POFF,
    input  logic          Sync,
    output logic          Vld,
    output logic [OW-1:0] Cos,
    output logic [OW-1:0] Sin,
    output logic          Wrap
);

    // One MSB of headroom above OW+2 so the CORDIC gain plus truncation drift never overflows.
    localparam int unsigned XW = OW + 3;
    localparam int unsigned ZW = AW + 1;
    localparam longint AMP = (longint'(1) << (OW - 1)) - 1;
    localparam longint X0  = ((AMP * 607253 + 500000) / 1000000) * 4;
    localparam int ATAN16 [16] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81,
                                   41, 20, 10, 5, 3, 1, 1, 0};
    localparam logic signed [XW-1:0] LIM_P = XW'(AMP);
    localparam logic signed [XW-1:0] LIM_N = XW'(-AMP);
    localparam logic signed [XW-1:0] RND   = XW'(2);

    function automatic logic signed [ZW-1:0] atan_f(input int unsigned i);
        return ZW'(ATAN16[i] >>> (16 - AW));
    endfunction

    function automatic logic [OW-1:0] sat_f(input logic signed [XW-1:0] v, input logic neg);
        logic signed [XW-1:0] n;
        logic signed [XW-1:0] r;
        n = neg ? -v : v;
        r = (n + RND) >>> 2;
        if (r > LIM_P) return LIM_P[OW-1:0];
        if (r < LIM_N) return LIM_N[OW-1:0];
        return r[OW-1:0];
    endfunction

    logic [PW-1:0] acc_q, acc_d;
    logic [PW-1:0] fcw_q, fcw_d;
    logic [PW-1:0] poff_q, poff_d;
    logic [PW-1:0] shf_q, shf_d;
    logic [PW-1:0] shp_q, shp_d;
    logic          pend_q, pend_d;
    logic          wrap_q, wrap_d;
    logic [PW:0]   sum;
    logic          commit;

    logic [AW-1:0] ph_q;
    logic          vph_q;
    logic [AW-1:0] pf;
    logic          flip;

    logic signed [XW-1:0] x_q [NSTG+1];
    logic signed [XW-1:0] y_q [NSTG+1];
    logic signed [ZW-1:0] z_q [NSTG];
    logic                 neg_q [NSTG+1];
    logic                 vs_q [NSTG+1];

    logic          vld_q;
    logic [OW-1:0] cos_q, sin_q;

    always_comb begin
        sum    = {1'b0, acc_q} + {1'b0, fcw_q};
        commit = (UPD_ON_WRAP != 0) && pend_q && (Sync || (En && sum[PW]));

        acc_d  = acc_q;
        wrap_d = 1'b0;
        if (Sync) begin
            acc_d = '0;
        end else if (En) begin
            acc_d  = sum[PW-1:0];
            wrap_d = sum[PW];
        end

        fcw_d  = fcw_q;
        poff_d = poff_q;
        shf_d  = shf_q;
        shp_d  = shp_q;
        pend_d = pend_q;
        if (UPD_ON_WRAP == 0) begin
            if (Ld) begin
                fcw_d  = FCW;
                poff_d = POFF;
            end
        end else begin
            // A Ld coinciding with a commit refills the shadow and keeps pending set.
            if (commit) begin
                fcw_d  = shf_q;
                poff_d = shp_q;
                pend_d = 1'b0;
            end
            if (Ld) begin
                shf_d  = FCW;
                shp_d  = POFF;
                pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            fcw_q  <= '0;
            poff_q <= '0;
            shf_q  <= '0;
            shp_q  <= '0;
            pend_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            fcw_q  <= fcw_d;
            poff_q <= poff_d;
            shf_q  <= shf_d;
            shp_q  <= shp_d;
            pend_q <= pend_d;
            wrap_q <= wrap_d;
        end
    end

    // Quadrants II/III are rotated by pi into I/IV and the result negated at the output.
    always_comb begin
        flip = ph_q[AW-1] ^ ph_q[AW-2];
        pf   = flip ? {~ph_q[AW-1], ph_q[AW-2:0]} : ph_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q  <= '0;
            vph_q <= 1'b0;
            for (int unsigned i = 0; i <= NSTG; i++) begin
                x_q[i]   <= '0;
                y_q[i]   <= '0;
                neg_q[i] <= 1'b0;
                vs_q[i]  <= 1'b0;
            end
            for (int unsigned i = 0; i < NSTG; i++) begin
                z_q[i] <= '0;
            end
            vld_q <= 1'b0;
            cos_q <= '0;
            sin_q <= '0;
        end else begin
            ph_q  <= AW'((acc_q + poff_q) >> (PW - AW));
            vph_q <= En;

            x_q[0]   <= XW'(X0);
            y_q[0]   <= '0;
            z_q[0]   <= $signed({pf[AW-1], pf});
            neg_q[0] <= flip;
            vs_q[0]  <= vph_q;

            for (int unsigned i = 0; i < NSTG; i++) begin
                neg_q[i+1] <= neg_q[i];
                vs_q[i+1]  <= vs_q[i];
                if (!z_q[i][ZW-1]) begin
                    x_q[i+1] <= x_q[i] - (y_q[i] >>> i);
                    y_q[i+1] <= y_q[i] + (x_q[i] >>> i);
                    if (i + 1 < NSTG) z_q[i+1] <= z_q[i] - atan_f(i);
                end else begin
                    x_q[i+1] <= x_q[i] + (y_q[i] >>> i);
                    y_q[i+1] <= y_q[i] - (x_q[i] >>> i);
                    if (i + 1 < NSTG) z_q[i+1] <= z_q[i] + atan_f(i);
                end
            end

            vld_q <= vs_q[NSTG];
            if (vs_q[NSTG]) begin
                cos_q <= sat_f(x_q[NSTG], neg_q[NSTG]);
                sin_q <= sat_f(y_q[NSTG], neg_q[NSTG]);
            end
        end
    end

    assign Vld  = vld_q;
    assign Cos  = cos_q;
    assign Sin  = sin_q;
    assign Wrap = wrap_q;

endmodule

// File: tb/tb_nco_param.sv
// Directed bench for nco_param: default instance plus a wrap-synchronised-update instance.
module tb_nco_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        En, Ld, Sync;
    logic [23:0] FCW, POFF;
    logic        Vld, Wrap;
    logic [11:0] Cos, Sin;

    logic        w_En, w_Ld, w_Sync;
    logic [23:0] w_FCW, w_POFF;
    logic        w_Vld, w_Wrap;
    logic [11:0] w_Cos, w_Sin;

    int n_chk = 0;
    int n_err = 0;

    nco_param #(.PW(24), .AW(16), .OW(12), .NSTG(12), .UPD_ON_WRAP(0)) dut (
        .clk(clk), .rst_n(rst_n), .En(En), .Ld(Ld), .FCW(FCW), .POFF(POFF),
        .Sync(Sync), .Vld(Vld), .Cos(Cos), .Sin(Sin), .Wrap(Wrap)
    );

    nco_param #(.PW(24), .AW(16), .OW(12), .NSTG(12), .UPD_ON_WRAP(1)) dut_w (
        .clk(clk), .rst_n(rst_n), .En(w_En), .Ld(w_Ld), .FCW(w_FCW), .POFF(w_POFF),
        .Sync(w_Sync), .Vld(w_Vld), .Cos(w_Cos), .Sin(w_Sin), .Wrap(w_Wrap)
    );

    always #5 clk = ~clk;

    function automatic int s12(input logic [11:0] v);
        return int'($signed(v));
    endfunction

    task automatic chk(input string tag, input int obs, input int exp, input int tol = 0);
        n_chk++;
        if (obs - exp > tol || exp - obs > tol) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for the next Vld after a launch edge; returns edges elapsed.
    task automatic wait_vld(output int lat);
        lat = 0;
        while (lat < 40) begin
            tick();
            lat++;
            if (Vld) break;
        end
    endtask

    task automatic one_sample(input string tag, input logic [23:0] poff, input int ec, input int es);
        int lat;
        Ld = 1'b1; FCW = '0; POFF = poff; Sync = 1'b1; En = 1'b0;
        tick();
        Ld = 1'b0; Sync = 1'b0; En = 1'b1;
        tick();
        En = 1'b0;
        wait_vld(lat);
        chk({tag, "_lat"}, lat, 14);
        chk({tag, "_cos"}, s12(Cos), ec, 4);
        chk({tag, "_sin"}, s12(Sin), es, 4);
    endtask

    initial begin
        int ec4 [4] = '{2047, 0, -2047, 0};
        int es4 [4] = '{0, 2047, 0, -2047};
        int pat [6] = '{1, 0, 1, 1, 0, 1};
        int pc  [6] = '{2047, 2047, 0, -2047, -2047, 0};
        int ps  [6] = '{0, 0, 2047, 0, 0, -2047};
        int lat;

        rst_n = 1'b0;
        En = 1'b0; Ld = 1'b0; Sync = 1'b0; FCW = '0; POFF = '0;
        w_En = 1'b0; w_Ld = 1'b0; w_Sync = 1'b0; w_FCW = '0; w_POFF = '0;
        #12;
        chk("rst_vld", Vld, 0);
        chk("rst_cos", s12(Cos), 0);
        chk("rst_sin", s12(Sin), 0);
        chk("rst_wrap", Wrap, 0);
        #10 rst_n = 1'b1;

        // Quarter-turn stepping from phase 0
        Ld = 1'b1; FCW = 24'h400000; POFF = '0; Sync = 1'b1;
        tick();
        Ld = 1'b0; Sync = 1'b0; En = 1'b1;
        for (int e = 1; e <= 22; e++) begin
            tick();
            chk("t1_wrap", Wrap, (e % 4 == 0) ? 1 : 0);
            if (e == 14) chk("t1_vld_early", Vld, 0);
            if (e >= 15) begin
                chk("t1_vld", Vld, 1);
                chk("t1_cos", s12(Cos), ec4[(e - 15) % 4], 4);
                chk("t1_sin", s12(Sin), es4[(e - 15) % 4], 4);
            end
        end
        En = 1'b0;
        repeat (20) tick();

        one_sample("t2_45", 24'h200000, 1447, 1447);
        one_sample("t2_m45", 24'hE00000, 1447, -1447);

        one_sample("t3_3fffff", 24'h3FFFFF, 0, 2047);
        one_sample("t3_400000", 24'h400000, 0, 2047);
        one_sample("t3_7fffff", 24'h7FFFFF, -2047, 0);
        one_sample("t3_800000", 24'h800000, -2047, 0);
        one_sample("t3_bfffff", 24'hBFFFFF, 0, -2047);
        one_sample("t3_c00000", 24'hC00000, 0, -2047);

        // Bubbled En pattern; Cos/Sin must hold through the bubbles
        Ld = 1'b1; FCW = 24'h400000; POFF = '0; Sync = 1'b1;
        tick();
        Ld = 1'b0; Sync = 1'b0;
        for (int e = 1; e <= 22; e++) begin
            En = (e <= 6) ? pat[e - 1][0] : 1'b0;
            tick();
            if (e == 14 || e == 21) chk("t4_vld_edge", Vld, 0);
            if (e >= 15 && e <= 20) begin
                chk("t4_vld", Vld, pat[e - 15]);
                chk("t4_cos", s12(Cos), pc[e - 15], 4);
                chk("t4_sin", s12(Sin), ps[e - 15], 4);
            end
        end

        En = 1'b1;
        tick();
        En = 1'b0;
        repeat (20) tick();
        Sync = 1'b1;
        tick();
        Sync = 1'b0; En = 1'b1;
        tick();
        En = 1'b0;
        wait_vld(lat);
        chk("t4_sync_lat", lat, 14);
        chk("t4_sync_cos", s12(Cos), 2047, 4);
        chk("t4_sync_sin", s12(Sin), 0, 4);

        // Asynchronous reset mid-stream
        Ld = 1'b1; FCW = 24'h400000; POFF = '0; Sync = 1'b1;
        tick();
        Ld = 1'b0; Sync = 1'b0; En = 1'b1;
        repeat (20) tick();
        chk("t6_pre_vld", Vld, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_vld", Vld, 0);
        chk("t6_cos", s12(Cos), 0);
        chk("t6_sin", s12(Sin), 0);
        chk("t6_wrap", Wrap, 0);
        En = 1'b0;
        #3 rst_n = 1'b1;
        tick();
        chk("t6_idle_vld", Vld, 0);
        Ld = 1'b1; FCW = '0; POFF = 24'h200000; Sync = 1'b1;
        tick();
        chk("t6_idle_vld2", Vld, 0);
        Ld = 1'b0; Sync = 1'b0; En = 1'b1;
        tick();
        En = 1'b0;
        wait_vld(lat);
        chk("t6_lat", lat, 14);
        chk("t6_cos", s12(Cos), 1447, 4);
        chk("t6_sin", s12(Sin), 1447, 4);

        // Wrap-synchronised update
        w_Ld = 1'b1; w_FCW = 24'h100000; w_POFF = '0;
        tick();
        w_Ld = 1'b0; w_Sync = 1'b1;
        tick();
        w_Sync = 1'b0; w_En = 1'b1;
        for (int e = 1; e <= 26; e++) begin
            w_Ld = (e == 4);
            if (e == 4) w_FCW = 24'h400000;
            tick();
            chk("t5_wrap", w_Wrap, (e == 16 || e == 20 || e == 24) ? 1 : 0);
        end
        w_Ld = 1'b0;
        chk("t5_vld", w_Vld, 1);
        w_En = 1'b0; w_Ld = 1'b1; w_FCW = 24'h200000;
        tick();
        w_Ld = 1'b0; w_Sync = 1'b1;
        tick();
        w_Sync = 1'b0; w_En = 1'b1;
        for (int e = 1; e <= 17; e++) begin
            tick();
            chk("t5_sync_wrap", w_Wrap, (e % 8 == 0) ? 1 : 0);
        end
        w_En = 1'b0;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
